fir_ctrl_sequencer: RTL and testbench

- Control front-end that sits directly upstream of ReConf_FirFilter and drives all of its control inputs from the 12 MHz clock.
- Generates the 600 kHz sample strobe (divide-by-20).
- Stages host coefficients and bursts them into the filter's four coefficient banks.
- Runs the per-sample memory-read/MAC burst, presenting the captured input pulse on the first cycle of each burst.

---
 rtl/fir_ctrl_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_fir_ctrl_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// fir_ctrl_sequencer
// Control front-end for ReConf_FirFilter, clocked from the 12 MHz clock.
//  - Divides the clock by DIV_N to make the 600 kHz sample strobe.
//  - On each strobe (when idle) runs an (NTAP+1)-cycle memory-read/MAC burst,
//    presenting the captured input pulse on the first burst cycle only.
//  - On a load request, stages NTAP host words per bank and bursts them into
//    each of the NBANK coefficient banks, followed by GAP_CYC idle cycles.
//
// Ports
//  iClk12M           12 MHz clock
//  iRsn              asynchronous active-low reset
//  iFirInRaw[2:0]    raw input pulse, captured on the strobe
//  iModuleSel[1:0]   bank for read bursts, captured on the strobe
//  iCoeffLoadStart   one-cycle request to reload all banks
//  iCoeffWrValid     host coefficient valid
//  iCoeffWrData      host coefficient word
//  oCoeffWrReady     host coefficient ready
//  oEnSample600k     one-cycle sample strobe
//  oCoeffUpdateFlag  coefficient write burst active
//  oMemRdFlag        read/MAC burst active
//  oModuleSel        bank presented to the filter
//  oWtDtRam          coefficient word presented to the filter
//  oFirIn            input pulse presented to the filter
//  oBusy             coefficient update in progress
//  oCoeffDone        pulse once the last bank has been written
// ---------------------------------------------------------------------------
module fir_ctrl_sequencer #(
    parameter int DIV_N   = 20,
    parameter int NTAP    = 10,
    parameter int NBANK   = 4,
    parameter int GAP_CYC = 5
) (
    input  logic        iClk12M,
    input  logic        iRsn,
    input  logic [2:0]  iFirInRaw,
    input  logic [1:0]  iModuleSel,
    input  logic        iCoeffLoadStart,
    input  logic        iCoeffWrValid,
    input  logic [15:0] iCoeffWrData,
    output logic        oCoeffWrReady,
    output logic        oEnSample600k,
    output logic        oCoeffUpdateFlag,
    output logic        oMemRdFlag,
    output logic [1:0]  oModuleSel,
    output logic [15:0] oWtDtRam,
    output logic [2:0]  oFirIn,
    output logic        oBusy,
    output logic        oCoeffDone
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_FILL, S_BURST, S_GAP
    } state_t;

    localparam logic [4:0] L_DIV_LAST = 5'(DIV_N - 1);
    localparam logic [3:0] L_NTAP     = 4'(NTAP);
    localparam logic [3:0] L_TAP_LAST = 4'(NTAP - 1);
    localparam logic [3:0] L_GAP_LAST = 4'(GAP_CYC - 1);
    localparam logic [1:0] L_BANK_LAST = 2'(NBANK - 1);

    state_t      r_state;
    logic [4:0]  r_div;
    logic [3:0]  r_cnt;     // shared cycle/word counter for the current state
    logic [1:0]  r_bank;
    logic        r_pend;    // load request that arrived while a read was running
    logic [15:0] r_stage [NTAP];

    logic w_hs;
    assign w_hs = (r_state == S_FILL) && iCoeffWrValid && oCoeffWrReady;

    // Free-running sample divider; strobe is registered so it lands one
    // cycle after the counter shows its last value.
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            r_div         <= '0;
            oEnSample600k <= 1'b0;
        end else begin
            oEnSample600k <= (r_div == L_DIV_LAST);
            r_div         <= (r_div == L_DIV_LAST) ? 5'd0 : r_div + 5'd1;
        end
    end

    // Staging contents are don't-care after reset, so no reset term here.
    always_ff @(posedge iClk12M) begin
        if (w_hs) r_stage[r_cnt] <= iCoeffWrData;
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            r_state          <= S_IDLE;
            r_cnt            <= '0;
            r_bank           <= '0;
            r_pend           <= 1'b0;
            oCoeffWrReady    <= 1'b0;
            oCoeffUpdateFlag <= 1'b0;
            oMemRdFlag       <= 1'b0;
            oModuleSel       <= '0;
            oWtDtRam         <= '0;
            oFirIn           <= '0;
            oBusy            <= 1'b0;
            oCoeffDone       <= 1'b0;
        end else begin
            oCoeffDone <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A strobe always wins; a simultaneous load is deferred.
                    if (oEnSample600k) begin
                        r_state    <= S_RD;
                        r_cnt      <= '0;
                        oMemRdFlag <= 1'b1;
                        oFirIn     <= iFirInRaw;
                        oModuleSel <= iModuleSel;
                        if (iCoeffLoadStart) r_pend <= 1'b1;
                    end else if (iCoeffLoadStart || r_pend) begin
                        r_state       <= S_FILL;
                        r_cnt         <= '0;
                        r_bank        <= '0;
                        oCoeffWrReady <= 1'b1;
                        oBusy         <= 1'b1;
                    end
                end
                S_RD: begin
                    if (iCoeffLoadStart) r_pend <= 1'b1;
                    oFirIn <= '0;           // sample shown on the first cycle only
                    if (r_cnt == L_NTAP) begin
                        r_state    <= S_IDLE;
                        oMemRdFlag <= 1'b0;
                        oModuleSel <= '0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_FILL: begin
                    if (w_hs) begin
                        if (r_cnt == L_TAP_LAST) begin
                            r_state          <= S_BURST;
                            r_cnt            <= '0;
                            oCoeffWrReady    <= 1'b0;
                            oCoeffUpdateFlag <= 1'b1;
                            oWtDtRam         <= '0;
                            oModuleSel       <= r_bank;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                S_BURST: begin
                    // Cycle 0 carries a zero word; cycle k carries stage[k-1].
                    if (r_cnt == L_NTAP) begin
                        r_state          <= S_GAP;
                        r_cnt            <= '0;
                        oCoeffUpdateFlag <= 1'b0;
                        oWtDtRam         <= '0;
                        oModuleSel       <= '0;
                    end else begin
                        oWtDtRam <= r_stage[r_cnt];
                        r_cnt    <= r_cnt + 4'd1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == L_GAP_LAST) begin
                        r_cnt <= '0;
                        if (r_bank == L_BANK_LAST) begin
                            r_state    <= S_IDLE;
                            r_pend     <= 1'b0;
                            oBusy      <= 1'b0;
                            oCoeffDone <= 1'b1;
                        end else begin
                            r_bank        <= r_bank + 2'd1;
                            r_state       <= S_FILL;
                            oCoeffWrReady <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fir_ctrl_sequencer
// Randomised bench with a schedule-based reference model: each decision the
// model makes writes the full future waveform of that activity into per-cycle
// expectation arrays, which are compared against the DUT every cycle.
// ---------------------------------------------------------------------------
module tb_fir_ctrl_sequencer;

    localparam int DIV_N   = 20;
    localparam int NTAP    = 10;
    localparam int NBANK   = 4;
    localparam int GAP_CYC = 5;
    localparam int NC      = 2048;

    logic        iClk12M;
    logic        iRsn;
    logic [2:0]  iFirInRaw;
    logic [1:0]  iModuleSel;
    logic        iCoeffLoadStart;
    logic        iCoeffWrValid;
    logic [15:0] iCoeffWrData;
    logic        oCoeffWrReady;
    logic        oEnSample600k;
    logic        oCoeffUpdateFlag;
    logic        oMemRdFlag;
    logic [1:0]  oModuleSel;
    logic [15:0] oWtDtRam;
    logic [2:0]  oFirIn;
    logic        oBusy;
    logic        oCoeffDone;

    fir_ctrl_sequencer #(
        .DIV_N(DIV_N), .NTAP(NTAP), .NBANK(NBANK), .GAP_CYC(GAP_CYC)
    ) dut (
        .iClk12M(iClk12M), .iRsn(iRsn),
        .iFirInRaw(iFirInRaw), .iModuleSel(iModuleSel),
        .iCoeffLoadStart(iCoeffLoadStart),
        .iCoeffWrValid(iCoeffWrValid), .iCoeffWrData(iCoeffWrData),
        .oCoeffWrReady(oCoeffWrReady), .oEnSample600k(oEnSample600k),
        .oCoeffUpdateFlag(oCoeffUpdateFlag), .oMemRdFlag(oMemRdFlag),
        .oModuleSel(oModuleSel), .oWtDtRam(oWtDtRam), .oFirIn(oFirIn),
        .oBusy(oBusy), .oCoeffDone(oCoeffDone)
    );

    initial iClk12M = 1'b0;
    always #5 iClk12M = ~iClk12M;

    int n_chk = 0;
    int n_err = 0;
    int c;                  // cycle index since reset release
    int done_cnt, exp_done, acc, stall_left, burst_c0;
    bit stall_arm;
    logic [15:0] hq [$];    // host coefficient queue

    // Expected-waveform schedule. ph: 0 free (model decides), 1 committed, 2 fill.
    int          ph     [NC];
    logic        e_rd   [NC];
    logic        e_flag [NC];
    logic        e_busy [NC];
    logic        e_done [NC];
    logic [1:0]  e_msel [NC];
    logic [15:0] e_wt   [NC];
    logic [2:0]  e_fin  [NC];
    logic [15:0] stg    [NTAP];
    bit          pend;
    int          bank, nw;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, c, got, exp);
        end
    endtask

    function automatic logic [31:0] dutv();
        return {5'b0, oEnSample600k, oCoeffWrReady, oCoeffUpdateFlag, oMemRdFlag,
                oModuleSel, oWtDtRam, oFirIn, oBusy, oCoeffDone};
    endfunction

    function automatic logic [31:0] ev(input int k);
        logic stb;
        stb = (k >= DIV_N) && (k % DIV_N == 0);
        return {5'b0, stb, logic'(ph[k] == 2), e_flag[k], e_rd[k],
                e_msel[k], e_wt[k], e_fin[k], e_busy[k], e_done[k]};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NC; k++) begin
            ph[k] = 0; e_rd[k] = 0; e_flag[k] = 0; e_busy[k] = 0; e_done[k] = 0;
            e_msel[k] = '0; e_wt[k] = '0; e_fin[k] = '0;
        end
        pend = 0; bank = 0; nw = 0; burst_c0 = -1;
    endtask

    task automatic open_fill(input int k);
        ph[k] = 2;
        e_busy[k] = 1'b1;
    endtask

    // Last word of a bank accepted in cycle c: lay out burst, gap and what follows.
    task automatic sched_burst();
        int k;
        burst_c0 = c + 1;
        for (int j = 0; j <= NTAP; j++) begin
            ph[c+1+j] = 1; e_flag[c+1+j] = 1'b1; e_busy[c+1+j] = 1'b1;
            e_msel[c+1+j] = 2'(bank);
            e_wt[c+1+j] = (j == 0) ? 16'h0 : stg[j-1];
        end
        for (int g = 0; g < GAP_CYC; g++) begin
            ph[c+NTAP+2+g] = 1; e_busy[c+NTAP+2+g] = 1'b1;
        end
        k = c + NTAP + 2 + GAP_CYC;
        if (bank == NBANK - 1) begin
            e_done[k] = 1'b1;
            pend = 0;
        end else begin
            bank++; nw = 0;
            open_fill(k);
        end
    endtask

    // Decide what cycle c (with the inputs currently driven) leads to.
    task automatic model_eval();
        bit stb;
        stb = (c >= DIV_N) && (c % DIV_N == 0);
        if (ph[c] == 0) begin
            if (stb) begin
                for (int k = 1; k <= NTAP + 1; k++) begin
                    ph[c+k] = 1; e_rd[c+k] = 1'b1; e_msel[c+k] = iModuleSel;
                end
                e_fin[c+1] = iFirInRaw;
                if (iCoeffLoadStart) pend = 1;
            end else if (iCoeffLoadStart || pend) begin
                bank = 0; nw = 0;
                open_fill(c + 1);
            end
        end else if (ph[c] == 1) begin
            if (e_rd[c] && iCoeffLoadStart) pend = 1;
        end else begin
            if (iCoeffWrValid) begin
                stg[nw] = iCoeffWrData;
                nw++;
            end
            if (nw == NTAP) sched_burst();
            else open_fill(c + 1);
        end
    endtask

    task automatic drive(input bit vwant, input bit ld, input logic [2:0] raw, input logic [1:0] sel);
        bit v;
        v = vwant && (hq.size() > 0);
        if (stall_left > 0) begin
            v = 0;
            stall_left--;
        end
        iCoeffWrValid   = v;
        iCoeffWrData    = (hq.size() > 0) ? hq[0] : 16'($urandom);
        iCoeffLoadStart = ld;
        iFirInRaw       = raw;
        iModuleSel      = sel;
    endtask

    task automatic step();
        model_eval();
        if (ph[c] == 2 && iCoeffWrValid) begin
            void'(hq.pop_front());
            acc++;
            if (stall_arm && acc == NTAP + 4) begin
                stall_left = 7;
                stall_arm  = 0;
            end
        end
        @(posedge iClk12M);
        c++;
        @(negedge iClk12M);
        if (oCoeffDone) done_cnt++;
        if (e_done[c]) exp_done++;
        chk("cyc", dutv(), ev(c));
    endtask

    task automatic release_rst();
        model_clear();
        hq.delete();
        c = 0; acc = 0; stall_left = 0; stall_arm = 0;
        drive(0, 0, 3'b0, 2'b0);
        iRsn = 1'b1;
        chk("rst_release", dutv(), ev(0));
    endtask

    initial begin
        int wait_n;
        iRsn = 1'b0;
        iFirInRaw = '0; iModuleSel = '0; iCoeffLoadStart = 0;
        iCoeffWrValid = 0; iCoeffWrData = '0;
        done_cnt = 0; exp_done = 0;
        repeat (2) @(negedge iClk12M);
        chk("rst_hold", dutv(), 32'h0);

        // Idle strobes, read of 111/01 at cycle 40, load in RD cycle 4,
        // then four banks with a 7-cycle valid stall inside bank 1.
        release_rst();
        for (int b = 0; b < NBANK; b++)
            for (int w = 0; w < NTAP; w++)
                hq.push_back(16'h0A00 + 16'(b) * 16'h0100 + 16'(w));
        stall_arm = 1;
        done_cnt = 0; exp_done = 0;
        while (c < 250) begin
            drive(1, c == 45, 3'b111, 2'b01);
            step();
        end
        chk("done_once", 32'(done_cnt), 32'd1);
        chk("words_used", 32'(hq.size()), 32'd0);

        // Random loads, valid patterns and samples.
        done_cnt = 0; exp_done = 0;
        while (c < 1800) begin
            if (hq.size() < 12)
                for (int w = 0; w < NTAP; w++) hq.push_back(16'($urandom));
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 59) == 0,
                  3'($urandom), 2'($urandom));
            step();
        end
        chk("rand_done", 32'(done_cnt), 32'(exp_done));

        // Request an update and pull reset in burst cycle 5.
        burst_c0 = -1;
        wait_n = 0;
        while (!(burst_c0 >= 0 && c == burst_c0 + 5) && wait_n < 200 && c < NC - 40) begin
            if (hq.size() < 12)
                for (int w = 0; w < NTAP; w++) hq.push_back(16'($urandom));
            drive(1, wait_n == 0, 3'b010, 2'b10);
            step();
            wait_n++;
        end
        chk("abort_reached", 32'(burst_c0 >= 0 && c == burst_c0 + 5), 32'd1);
        #2 iRsn = 1'b0;
        #1 chk("async_rst", dutv(), 32'h0);
        repeat (2) @(negedge iClk12M);
        chk("rst_hold2", dutv(), 32'h0);

        // After abort: divider from 0, idle, and a full reload starting at bank 0.
        release_rst();
        for (int b = 0; b < NBANK; b++)
            for (int w = 0; w < NTAP; w++) hq.push_back(16'($urandom));
        done_cnt = 0; exp_done = 0;
        while (c < 250) begin
            drive(c > 50, c == 50, 3'b101, 2'b11);
            step();
        end
        chk("done_after_rst", 32'(done_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
